// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source select, FSM states,
// RISC-V load funct3 encodings and the load alignment rule.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // off is always three bits wide; narrower datapaths zero-extend their offset.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3)
      F3_LH, F3_LHU: return off[0];
      F3_LW, F3_LWU: return off[1:0] != 2'b00;
      F3_LD:         return off != 3'b000;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: extracts the addressed byte/half/word from the
// raw memory word, sign- or zero-extends it, and flags misaligned/illegal loads.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   byte_off,
  input  logic [XLEN-1:0]             raw_data,
  output logic [XLEN-1:0]             data,
  output logic                        err
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic [XLEN-1:0] shifted;
  logic [2:0]      off3;
  logic            illegal;

  always_comb begin
    shifted = raw_data >> {byte_off, 3'b000};
    off3 = '0;
    off3[OFF_W-1:0] = byte_off;
    illegal = (funct3 == 3'b111) ||
              ((XLEN == 32) && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
    err = illegal || is_misaligned(funct3, off3);

    // Fill with the sign bit first, then overwrite the payload bits.
    data = '0;
    case (funct3)
      F3_LB: begin
        data = {XLEN{shifted[7]}};
        data[7:0] = shifted[7:0];
      end
      F3_LBU: data[7:0] = shifted[7:0];
      F3_LH: begin
        data = {XLEN{shifted[15]}};
        data[15:0] = shifted[15:0];
      end
      F3_LHU: data[15:0] = shifted[15:0];
      F3_LW: begin
        data = {XLEN{shifted[31]}};
        data[31:0] = shifted[31:0];
      end
      F3_LWU: data[31:0] = shifted[31:0];
      F3_LD:  data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: picks the result source, waits for load data when needed,
// and drives the register-file write port plus a retired-instruction counter.
module write_back_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_reg_write,
  input  logic [4:0]                  in_rd,
  input  wb_sel_e                     in_wb_sel,
  input  logic [2:0]                  in_funct3,
  input  logic [$clog2(XLEN/8)-1:0]   in_byte_off,
  input  logic [XLEN-1:0]             in_alu_result,
  input  logic [XLEN-1:0]             in_pc_plus4,
  input  logic [XLEN-1:0]             in_imm,
  input  logic                        mem_rsp_valid,
  input  logic [XLEN-1:0]             mem_rsp_data,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [XLEN-1:0]             rf_wdata,
  output logic                        misalign_err,
  output logic [CNT_W-1:0]            retire_count
);

  localparam int OFF_W = $clog2(XLEN/8);

  wb_state_e         state, state_next;
  logic              pend_reg_write;
  logic [4:0]        pend_rd;
  logic [2:0]        pend_funct3;
  logic [OFF_W-1:0]  pend_off;

  logic              accept;
  logic              latch_load;
  logic              wr_done;
  logic              ld_err;
  logic              wr_reg_write;
  logic [4:0]        wr_rd;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   align_data;
  logic              align_err;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3   (pend_funct3),
    .byte_off (pend_off),
    .raw_data (mem_rsp_data),
    .data     (align_data),
    .err      (align_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // wr_done marks a completed instruction whose result updates the write port.
  always_comb begin
    state_next   = state;
    latch_load   = 1'b0;
    wr_done      = 1'b0;
    ld_err       = 1'b0;
    wr_reg_write = 1'b0;
    wr_rd        = '0;
    wr_data      = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_wb_sel == WB_MEM) begin
            latch_load = 1'b1;
            state_next = WAIT_MEM;
          end else begin
            wr_done      = 1'b1;
            wr_reg_write = in_reg_write;
            wr_rd        = in_rd;
            case (in_wb_sel)
              WB_PC4:  wr_data = in_pc_plus4;
              WB_IMM:  wr_data = in_imm;
              default: wr_data = in_alu_result;
            endcase
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          state_next = IDLE;
          if (align_err) begin
            ld_err = 1'b1;
          end else begin
            wr_done      = 1'b1;
            wr_reg_write = pend_reg_write;
            wr_rd        = pend_rd;
            wr_data      = align_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A faulting load still retires but leaves the write-port data untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      misalign_err   <= 1'b0;
      retire_count   <= '0;
      pend_reg_write <= 1'b0;
      pend_rd        <= '0;
      pend_funct3    <= '0;
      pend_off       <= '0;
    end else begin
      rf_we        <= wr_done && wr_reg_write && (wr_rd != 5'd0);
      misalign_err <= ld_err;
      if (wr_done) begin
        rf_waddr <= wr_rd;
        rf_wdata <= wr_data;
      end
      if (wr_done || ld_err) retire_count <= retire_count + CNT_W'(1);
      if (latch_load) begin
        pend_reg_write <= in_reg_write;
        pend_rd        <= in_rd;
        pend_funct3    <= in_funct3;
        pend_off       <= in_byte_off;
      end
    end
  end

endmodule
